// File: rtl/cic_interpolator.sv
// cic_interpolator: N-stage CIC upsampler by INTERPOLATION_RATIO with gain-scaled, truncated output.
// Defining CIC_UNDERFLOW_COUNT_EN adds the saturating underflow_count output.
module cic_interpolator #(
   parameter int INPUT_WIDTH         = 12,
   parameter int REGISTER_WIDTH      = 64,
   parameter int INTERPOLATION_RATIO = 16,
   parameter int GAIN_WIDTH          = 8,
   parameter int NUM_STAGES          = 5
) (
   input  logic                          clk,
   input  logic                          arst_n,
   input  logic [GAIN_WIDTH-1:0]         gain,
   input  logic signed [INPUT_WIDTH-1:0] data_in,
   input  logic                          data_in_valid,
   output logic                          data_in_ready,
   output logic signed [INPUT_WIDTH-1:0] data_out,
   output logic                          data_out_valid,
   output logic                          data_clk
`ifdef CIC_UNDERFLOW_COUNT_EN
   ,
   output logic [15:0]                   underflow_count
`endif
);
   localparam int CW    = $clog2(INTERPOLATION_RATIO);
   localparam int HR    = REGISTER_WIDTH - INPUT_WIDTH;
   localparam int LAT   = (NUM_STAGES - 1) * INTERPOLATION_RATIO + NUM_STAGES + 1;
   localparam int LW    = $clog2(LAT + 1);
   localparam int SW    = (GAIN_WIDTH > 32) ? GAIN_WIDTH : 32;

   generate
      if (INTERPOLATION_RATIO < 2 || (INTERPOLATION_RATIO & (INTERPOLATION_RATIO - 1)) != 0)
         $error("INTERPOLATION_RATIO must be a power of two >= 2");
      if (NUM_STAGES < 1 || NUM_STAGES > 8)
         $error("NUM_STAGES must be in 1..8");
      if (REGISTER_WIDTH < INPUT_WIDTH + (NUM_STAGES - 1) * $clog2(INTERPOLATION_RATIO) + 1)
         $error("REGISTER_WIDTH too small for the CIC growth");
   endgenerate

   logic [CW-1:0]                    r_count;
   logic [CW-1:0]                    w_count_nxt;
   logic                             w_slot;
   logic signed [REGISTER_WIDTH-1:0] w_x;
   logic signed [REGISTER_WIDTH-1:0] w_u;
   logic signed [REGISTER_WIDTH-1:0] r_comb    [NUM_STAGES];
   logic signed [REGISTER_WIDTH-1:0] r_dly     [NUM_STAGES];
   logic signed [REGISTER_WIDTH-1:0] r_int     [NUM_STAGES];
   logic signed [REGISTER_WIDTH-1:0] w_comb_in [NUM_STAGES];
   logic signed [REGISTER_WIDTH-1:0] w_int_in  [NUM_STAGES];
   logic [SW-1:0]                    w_gain;
   logic [SW-1:0]                    w_shift;
   logic                             r_seen;
   logic [LW-1:0]                    r_lat;

   always_comb begin
      w_count_nxt = r_count + CW'(1);
      w_slot      = r_count == '0;
      w_x         = (w_slot && data_in_valid)
                    ? {{(REGISTER_WIDTH-INPUT_WIDTH){data_in[INPUT_WIDTH-1]}}, data_in} : '0;
      w_u         = (r_count == CW'(1)) ? r_comb[NUM_STAGES-1] : '0;
      w_gain      = SW'(gain);
      w_shift     = (w_gain > SW'(HR)) ? '0 : SW'(HR) - w_gain;
      w_comb_in[0] = w_x;
      w_int_in[0]  = w_u;
      for (int k = 1; k < NUM_STAGES; k++) begin
         w_comb_in[k] = r_comb[k-1];
         w_int_in[k]  = r_int[k-1];
      end
   end

   // combs step once per slot; integrators run every clock and may wrap freely
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         for (int k = 0; k < NUM_STAGES; k++) begin
            r_comb[k] <= '0;
            r_dly[k]  <= '0;
            r_int[k]  <= '0;
         end
      end else begin
         for (int k = 0; k < NUM_STAGES; k++) begin
            if (w_slot) begin
               r_comb[k] <= w_comb_in[k] - r_dly[k];
               r_dly[k]  <= w_comb_in[k];
            end
            r_int[k] <= r_int[k] + w_int_in[k];
         end
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_count        <= CW'(INTERPOLATION_RATIO - 1);
         data_in_ready  <= 1'b0;
         data_clk       <= 1'b0;
         data_out       <= '0;
         data_out_valid <= 1'b0;
         r_seen         <= 1'b0;
         r_lat          <= '0;
      end else begin
         r_count       <= w_count_nxt;
         data_in_ready <= r_count == CW'(INTERPOLATION_RATIO - 1);
         data_clk      <= !w_count_nxt[CW-1];
         data_out      <= INPUT_WIDTH'(r_int[NUM_STAGES-1] >>> w_shift);
         if (w_slot && data_in_valid)
            r_seen <= 1'b1;
         // valid rises when the first accepted sample reaches data_out
         if (r_seen && !data_out_valid)
            r_lat <= r_lat + LW'(1);
         if (r_seen && r_lat == LW'(LAT - 1))
            data_out_valid <= 1'b1;
      end
   end

`ifdef CIC_UNDERFLOW_COUNT_EN
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n)
         underflow_count <= '0;
      else if (w_slot && !data_in_valid && data_out_valid && underflow_count != 16'hFFFF)
         underflow_count <= underflow_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_cic_interpolator.sv
// tb_cic_interpolator: scoreboard bench comparing the CIC output against a direct
// convolution with the boxcar^N impulse response of the interpolator.
`timescale 1ns/1ps
module tb_cic_interpolator;
   localparam int IW  = 12;
   localparam int RW  = 64;
   localparam int R   = 16;
   localparam int GW  = 8;
   localparam int N   = 5;
   localparam int HL  = N * (R - 1) + 1;
   localparam int LAT = (N - 1) * R + N + 1;

   logic                 clk = 1'b0;
   logic                 arst_n = 1'b0;
   logic [GW-1:0]        gain = '0;
   logic signed [IW-1:0] data_in = '0;
   logic                 data_in_valid = 1'b0;
   logic                 data_in_ready;
   logic signed [IW-1:0] data_out;
   logic                 data_out_valid;
   logic                 data_clk;
`ifdef CIC_UNDERFLOW_COUNT_EN
   logic [15:0]          underflow_count;
`endif

   int n_chk = 0;
   int n_fail = 0;
   int n = 0;
   int first_e = -1;
   longint h [HL];
   longint xs [$];
   logic signed [IW-1:0] exp_q [$];

   cic_interpolator #(
      .INPUT_WIDTH(IW), .REGISTER_WIDTH(RW), .INTERPOLATION_RATIO(R),
      .GAIN_WIDTH(GW), .NUM_STAGES(N)
   ) dut (
      .clk(clk),
      .arst_n(arst_n),
      .gain(gain),
      .data_in(data_in),
      .data_in_valid(data_in_valid),
      .data_in_ready(data_in_ready),
      .data_out(data_out),
      .data_out_valid(data_out_valid),
      .data_clk(data_clk)
`ifdef CIC_UNDERFLOW_COUNT_EN
      ,
      .underflow_count(underflow_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input longint got, input longint want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s (n=%0d): got %0d expected %0d", tag, n, got, want);
      end
   endtask

   function automatic logic signed [IW-1:0] scale(input longint acc, input int g);
      int s;
      longint v;
      s = (g > RW - IW) ? 0 : RW - IW - g;
      v = acc >>> s;
      return v[IW-1:0];
   endfunction

   // drive one input slot and queue the R outputs whose window ends with it
   task automatic drive_slot(input logic v, input logic signed [IW-1:0] d, input int g);
      longint acc;
      int idx;
      data_in = d;
      data_in_valid = v;
      xs.push_back(v ? longint'(d) : 64'sd0);
      if (v && first_e < 0) first_e = n + 1;
      for (int j = 0; j < R; j++) begin
         acc = 0;
         for (int k = 0; k < xs.size(); k++) begin
            idx = R * (xs.size() - 1 - k) + j;
            if (idx < HL) acc += xs[k] * h[idx];
         end
         exp_q.push_back(scale(acc, g));
      end
   endtask

   task automatic cycle_check();
      @(posedge clk);
      #1;
      n++;
      check("ready", data_in_ready, (n % R) == 1);
      check("data_clk", data_clk, ((n - 1) % R) < R / 2);
      check("out_valid", data_out_valid, first_e >= 0 && n >= first_e + LAT);
      if (n >= 2 + LAT) begin
         if (exp_q.size() > 0) check("data_out", data_out, exp_q.pop_front());
         else check("sb_depth", exp_q.size(), 1);
      end else
         check("out_pre_latency", data_out, 0);
      if (n % R == 2) data_in = IW'($urandom);
   endtask

   task automatic run_phase(input int g, input logic signed [IW-1:0] d, input int slots,
                            input int pre, input int lo, input int hi, input int exp_uf);
      int m;
      @(posedge clk);
      #1;
      arst_n = 1'b0;
      gain = GW'(g);
      #1;
      check("rst_data_out", data_out, 0);
      check("rst_out_valid", data_out_valid, 0);
      check("rst_ready", data_in_ready, 0);
      check("rst_data_clk", data_clk, 0);
`ifdef CIC_UNDERFLOW_COUNT_EN
      check("rst_uflow", underflow_count, 0);
`endif
      @(posedge clk);
      #1;
      arst_n = 1'b1;
      n = 0;
      first_e = -1;
      xs.delete();
      exp_q.delete();
      for (int c = 0; c < slots * R; c++) begin
         if (n % R == 1) begin
            m = (n - 1) / R;
            drive_slot(!(m < pre || (m >= lo && m <= hi)), d, g);
         end
         cycle_check();
      end
`ifdef CIC_UNDERFLOW_COUNT_EN
      check("uflow", underflow_count, exp_uf);
`else
      check("uflow_slots", lo >= 0 ? hi - lo + 1 : 0, exp_uf);
`endif
   endtask

   initial begin
      longint t [HL];
      for (int i = 0; i < HL; i++) h[i] = 0;
      h[0] = 1;
      for (int st = 0; st < N; st++) begin
         for (int i = 0; i < HL; i++) t[i] = 0;
         for (int i = 0; i < HL; i++)
            for (int j = 0; j < R; j++)
               if (i + j < HL) t[i+j] += h[i];
         h = t;
      end
      repeat (3) @(posedge clk);
      run_phase(36, 12'sd0,     8, 0, -1, -1, 0);
      run_phase(36, 12'sd100,  14, 0, -1, -1, 0);
      run_phase(36, -12'sd2048, 14, 0, -1, -1, 0);
      run_phase(36, 12'sd100,  22, 2,  8, 10, 3);
      run_phase(35, 12'sd100,  14, 0, -1, -1, 0);
      run_phase(200, 12'sd100, 10, 0, -1, -1, 0);
      run_phase(36, 12'sd100,  14, 0, -1, -1, 0);
      run_phase(37, -12'sd777, 14, 0, 9, 9, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/cic_interpolator.md
Name: cic_interpolator

Overview:
- N-stage Cascaded Integrator-Comb interpolator. It upsamples a low-rate signed sample stream by INTERPOLATION_RATIO; it is the transmit-side counterpart of the CIC decimator.
- Comb section runs at the input (slot) rate. A zero-stuffing upsampler sits between the sections. The integrator section runs at clk rate.
- Output is gain-scaled and truncated back to INPUT_WIDTH, one sample per clk. It feeds the DAC/upconversion path.

Parameters:
- INPUT_WIDTH, 12, width of data_in and data_out (signed).
- REGISTER_WIDTH, 64, width of all comb and integrator registers. Must be >= INPUT_WIDTH + (NUM_STAGES-1)*log2(INTERPOLATION_RATIO) + 1.
- INTERPOLATION_RATIO, 16, upsampling factor R. Must be a power of two and >= 2; violation is an elaboration $error.
- GAIN_WIDTH, 8, width of gain.
- NUM_STAGES, 5, number of comb stages and number of integrator stages N. Legal range 1..8.

Ports:
- clk  input  1  system clock.
- arst_n  input  1  asynchronous, active-low reset.
- gain  input  GAIN_WIDTH  output scaling control (unsigned).
- data_in  input  INPUT_WIDTH  signed input sample.
- data_in_valid  input  1  data_in holds a valid sample.
- data_in_ready  output  1  block accepts data_in this cycle.
- data_out  output  INPUT_WIDTH  signed interpolated sample.
- data_out_valid  output  1  data_out is meaningful.
- data_clk  output  1  input-rate strobe clock, ~50% duty.
- underflow_count  output  16  present only with CIC_UNDERFLOW_COUNT_EN.

Behaviour:
- Reset (arst_n low, asynchronous): all comb, comb-delay and integrator registers go to 0. count goes to R-1.
- Reset values of outputs: data_in_ready=0, data_out=0, data_out_valid=0, data_clk=0, underflow_count=0.
- Asserting reset mid-operation discards all state. Behaviour after release is identical to power-up.
- Phase counter: count is free-running from 0 to R-1 and wraps to 0. It is not stalled by the handshake.
- data_in_ready is registered, loaded with (count==R-1). It is therefore high exactly during the cycles where count==0. The first ready cycle is the 2nd cycle after reset release.
- Slot edge: the rising edge where count==0.
  - If data_in_valid=1 at the slot edge, data_in is accepted. x is data_in sign-extended to REGISTER_WIDTH.
  - If data_in_valid=0 at the slot edge, x=0 (underflow). No stall occurs and the output stream continues.
  - data_in_valid outside the ready cycle is ignored.
- Combs update only on slot edges:
  - c1 <= x - x_d, then x_d <= x.
  - ck <= c(k-1) - c(k-1)_d, then c(k-1)_d <= c(k-1), for k = 2..N.
  - Each stage adds one slot of latency.
- Upsampler: u = cN when count==1, otherwise u = 0. There is exactly one nonzero slot per R clocks.
- Integrators update every clk:
  - i1 <= i1 + u.
  - ik <= ik + i(k-1), for k = 2..N.
  - Each stage adds one clk of latency.
- Arithmetic is two's-complement modulo 2^REGISTER_WIDTH. Integrator wrap-around is legal and must not be saturated.
- Output register:
  - data_out <= iN >>> s, where s = REGISTER_WIDTH - INPUT_WIDTH - gain. The result is truncated to the low INPUT_WIDTH bits.
  - If gain > REGISTER_WIDTH - INPUT_WIDTH, s is clamped to 0.
- DC gain: steady-state output = x * R^(N-1) / 2^s. With the defaults (R=16, N=5), R^(N-1) = 2^16, so gain=36 (s=16) gives unity gain.
- Latency: the first clk of data_out influenced by a sample accepted at slot edge E occurs (N-1)*R + N + 1 clocks after E. With the defaults this is 70.
- data_out_valid:
  - Set on the same edge that the first accepted sample after reset first affects data_out.
  - Remains 1 until reset, including across underflow slots.
  - Underflow slots before the first accept do not set it.
- data_clk is registered and is high during the cycles with count in [0, R/2-1].
- gain is sampled every clk. A gain change takes effect on the next data_out update.

Optional Feature:
- Macro: CIC_UNDERFLOW_COUNT_EN.
- When defined: underflow_count port exists. It increments on every slot edge with data_in_valid=0 that occurs after data_out_valid has been set. It saturates at 16'hFFFF and resets to 0.
- When undefined: the port and its counter are absent. Underflow still inserts zeros silently.

Test Plan:
1. Reset release; hold data_in_valid=1 with data_in=0 -> data_in_ready first high in the 2nd cycle after release, then every 16th cycle. data_clk is high 8 clocks and low 8 clocks. data_out stays 0.
2. gain=36; constant data_in=100 with valid held high -> data_out_valid rises 70 clocks after the first accept edge. data_out rises monotonically and settles at exactly 100 every cycle.
3. gain=36; constant data_in=-2048 (most negative) -> settles at -2048 with no glitches. Integrator wrap is allowed internally, but the output must be correct.
4. gain=36; data_in=100 with valid low for 3 slots mid-stream -> data_in_ready keeps its 16-cycle cadence. Output dips then recovers to 100. With CIC_UNDERFLOW_COUNT_EN, underflow_count=3.
5. gain=35 with data_in=100 -> output settles at 50. gain=200 (clamped, s=0) -> data_out equals the low 12 bits of iN.
6. Assert arst_n low for 1 cycle mid-stream -> all outputs read 0 and count restarts. The first accept lands in the 2nd cycle after release, and the latency repeats test 2.
